// File: rtl/gpio_in_filter_pkg.sv
// gpio_in_filter_pkg: shared register offsets, CFG field layout and counter width
//   GPIO_IN_* : 4-bit register offsets decoded from addr_i[3:0]
//   CFG_*     : bit positions of THR and EN inside CFG
//   CNT_W     : debounce/edge counter width
package gpio_in_filter_pkg;
    localparam logic [3:0] GPIO_IN_CFG     = 4'h0;
    localparam logic [3:0] GPIO_IN_STATUS  = 4'h4;
    localparam logic [3:0] GPIO_IN_IRQEN   = 4'h8;
    localparam logic [3:0] GPIO_IN_EDGECNT = 4'hC;
    localparam int CFG_THR_LSB = 0;
    localparam int CFG_THR_W   = 16;
    localparam int CFG_EN_BIT  = 16;
    localparam int CNT_W       = 16;
    typedef struct packed {
        logic             en;
        logic [CNT_W-1:0] thr;
    } cfg_t;
    // A threshold of zero behaves like one so a change always takes at least a cycle.
    function automatic logic [CNT_W-1:0] eff_thr(input logic [CNT_W-1:0] t);
        return t == '0 ? CNT_W'(1) : t;
    endfunction
endpackage

// File: rtl/gpio_in_debounce_cell.sv
// gpio_in_debounce_cell: one pin's synchroniser, debounce counter and filtered level flop
//   clk, rst  : clock, synchronous active-high reset
//   en, thr   : debounce enable and threshold from CFG
//   pin_async : raw pad input
//   filt      : registered debounced level
//   filt_nxt  : value filt takes at the next edge (used for edge capture)
module gpio_in_debounce_cell
    import gpio_in_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] thr,
    input  logic             pin_async,
    output logic             filt,
    output logic             filt_nxt
);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   s, hit;
    assign s   = sync[SYNC_STAGES-1];
    // cnt+1 >= thr without widening; eff_thr is never zero
    assign hit = cnt >= eff_thr(thr) - 1'b1;
    always_comb begin
        filt_nxt = (!en || (s != filt && hit)) ? s : filt;
        cnt_nxt  = (!en || s == filt || hit) ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            filt <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin_async};
            cnt  <= cnt_nxt;
            filt <= filt_nxt;
        end
    end
endmodule

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: synchronise, debounce and edge-capture GPIO pad inputs
//   clk, rst    : clock, synchronous active-high reset
//   we_i        : bus write strobe
//   addr_i      : bus address, [3:0] decoded
//   data_i      : bus write data
//   data_o      : combinational read data
//   pin_async_i : raw pad inputs
//   filt_o      : debounced levels to the GPIO block
//   irq_o       : |(status & irq_en)
// Optional: define GPIO_IN_FILTER_EDGE_CNT_EN to add the pin-0 rising edge counter at 0xC.
module gpio_in_filter
    import gpio_in_filter_pkg::*;
#(
    parameter int          NUM_PINS    = 10,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DB_RST      = 16'd16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    input  logic [NUM_PINS-1:0] pin_async_i,
    output logic [NUM_PINS-1:0] filt_o,
    output logic                irq_o
);
    cfg_t                cfg;
    logic [NUM_PINS-1:0] filt_nxt, rise_set, fall_set;
    logic [NUM_PINS-1:0] rise, fall, irq_rise, irq_fall;
    logic                wr_cfg, wr_status, wr_irqen;
    logic [31:0]         cfg_rd, status_rd, irqen_rd, ec_rd;
    logic                unused_bus;
    assign unused_bus = ^{addr_i[31:4], data_i};
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_cell
        gpio_in_debounce_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
            .clk       (clk),
            .rst       (rst),
            .en        (cfg.en),
            .thr       (cfg.thr),
            .pin_async (pin_async_i[i]),
            .filt      (filt_o[i]),
            .filt_nxt  (filt_nxt[i])
        );
    end
    assign rise_set  = filt_nxt & ~filt_o;
    assign fall_set  = ~filt_nxt & filt_o;
    assign wr_cfg    = we_i && addr_i[3:0] == GPIO_IN_CFG;
    assign wr_status = we_i && addr_i[3:0] == GPIO_IN_STATUS;
    assign wr_irqen  = we_i && addr_i[3:0] == GPIO_IN_IRQEN;
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg      <= '{en: 1'b1, thr: DB_RST};
            rise     <= '0;
            fall     <= '0;
            irq_rise <= '0;
            irq_fall <= '0;
        end else begin
            if (wr_cfg) begin
                cfg.thr <= data_i[CFG_THR_LSB +: CFG_THR_W];
                cfg.en  <= data_i[CFG_EN_BIT];
            end
            if (wr_irqen) begin
                irq_rise <= data_i[NUM_PINS-1:0];
                irq_fall <= data_i[16 +: NUM_PINS];
            end
            // OR-ing the set term last lets a new edge win over a same-cycle clear
            rise <= (rise & ~(wr_status ? data_i[NUM_PINS-1:0] : '0)) | rise_set;
            fall <= (fall & ~(wr_status ? data_i[16 +: NUM_PINS] : '0)) | fall_set;
        end
    end
`ifdef GPIO_IN_FILTER_EDGE_CNT_EN
    logic [CNT_W-1:0] edge_cnt;
    always_ff @(posedge clk) begin
        if (rst || (we_i && addr_i[3:0] == GPIO_IN_EDGECNT))
            edge_cnt <= '0;
        else if (rise_set[0])
            edge_cnt <= edge_cnt + 1'b1;
    end
    assign ec_rd = {{(32-CNT_W){1'b0}}, edge_cnt};
`else
    assign ec_rd = '0;
`endif
    always_comb begin
        cfg_rd    = '0;
        status_rd = '0;
        irqen_rd  = '0;
        cfg_rd[CFG_THR_LSB +: CFG_THR_W] = cfg.thr;
        cfg_rd[CFG_EN_BIT]               = cfg.en;
        status_rd[NUM_PINS-1:0]          = rise;
        status_rd[16 +: NUM_PINS]        = fall;
        irqen_rd[NUM_PINS-1:0]           = irq_rise;
        irqen_rd[16 +: NUM_PINS]         = irq_fall;
        data_o = rst                               ? '0 :
                 addr_i[3:0] == GPIO_IN_CFG     ? cfg_rd :
                 addr_i[3:0] == GPIO_IN_STATUS  ? status_rd :
                 addr_i[3:0] == GPIO_IN_IRQEN   ? irqen_rd :
                 addr_i[3:0] == GPIO_IN_EDGECNT ? ec_rd : '0;
    end
    assign irq_o = !rst && |{rise & irq_rise, fall & irq_fall};
endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: table, directed and randomized checks of gpio_in_filter against a streak-based model
module tb_gpio_in_filter;
    localparam int NP = 10;
    localparam int SS = 2;
    localparam logic [31:0] VM = {{(16-NP){1'b0}}, {NP{1'b1}}, {(16-NP){1'b0}}, {NP{1'b1}}};
`ifdef GPIO_IN_FILTER_EDGE_CNT_EN
    localparam int EC_ON = 1;
`else
    localparam int EC_ON = 0;
`endif
    logic          clk = 1'b0, rst = 1'b1, we = 1'b0;
    logic [31:0]   addr = '0, wdata = '0, rdata;
    logic [NP-1:0] pins = '0, filt;
    logic          irq;
    int            checks = 0, failures = 0;

    gpio_in_filter #(.NUM_PINS(NP), .SYNC_STAGES(SS), .DB_RST(16'd16)) dut (
        .clk(clk), .rst(rst), .we_i(we), .addr_i(addr), .data_i(wdata), .data_o(rdata),
        .pin_async_i(pins), .filt_o(filt), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Model: a pin's filtered level takes the synchronised value once that value has
    // been held for T consecutive edges (T = max(THR,1), or 1 when disabled).
    logic [NP-1:0] pin_q[$];
    logic [NP-1:0] m_filt, m_prev_s;
    int            streak[NP];
    logic [15:0]   m_thr, m_ec;
    logic          m_en;
    logic [31:0]   m_stat, m_irqen;

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        case (a[3:0])
            4'h0: return {15'b0, m_en, m_thr};
            4'h4: return m_stat;
            4'h8: return m_irqen;
            4'hC: return EC_ON ? {16'b0, m_ec} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        pin_q.delete();
        for (int k = 0; k < SS; k++) pin_q.push_back('0);
        m_filt = '0;
        m_prev_s = '0;
        for (int p = 0; p < NP; p++) streak[p] = 0;
        m_thr = 16'd16;
        m_en = 1'b1;
        m_stat = '0;
        m_irqen = '0;
        m_ec = '0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [NP-1:0] s, nf;
        logic [31:0]   set_v;
        int            t;
        if (rst) model_reset();
        else begin
            s = pin_q[0];
            t = !m_en ? 1 : (m_thr == 16'd0 ? 1 : int'(m_thr));
            nf = m_filt;
            for (int p = 0; p < NP; p++) begin
                streak[p] = (s[p] == m_prev_s[p]) ? streak[p] + 1 : 1;
                if (s[p] != m_filt[p] && streak[p] >= t) nf[p] = s[p];
            end
            m_prev_s = s;
            set_v = '0;
            set_v[NP-1:0] = nf & ~m_filt;
            set_v[16 +: NP] = m_filt & ~nf;
            if (we && addr[3:0] == 4'h4) m_stat = m_stat & ~wdata;
            m_stat = (m_stat | set_v) & VM;
            if (we && addr[3:0] == 4'hC) m_ec = '0;
            else if (nf[0] && !m_filt[0]) m_ec = m_ec + 16'd1;
            if (we && addr[3:0] == 4'h0) begin
                m_thr = wdata[15:0];
                m_en = wdata[16];
            end
            if (we && addr[3:0] == 4'h8) m_irqen = wdata & VM;
            m_filt = nf;
            pin_q.push_back(pins);
            void'(pin_q.pop_front());
        end
        @(posedge clk);
        #1;
        chk("filt_o", 32'(filt), 32'(m_filt));
        chk("irq_o", 32'(irq), 32'(!rst && |(m_stat & m_irqen)));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] e);
        we = 1'b0;
        addr = a;
        #1;
        chk(n, rdata, e);
    endtask

    task automatic wait_filt(input string n, input int p, input logic v, input int exp_n);
        int cnt_t = 0;
        while (filt[p] !== v && cnt_t < 400) begin
            tick();
            cnt_t++;
        end
        chk(n, cnt_t, exp_n);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[15];

    initial begin
        tv[0]  = '{1'b0, 32'h0,  32'h0,        32'h0001_0010};
        tv[1]  = '{1'b0, 32'h4,  32'h0,        32'h0};
        tv[2]  = '{1'b0, 32'h8,  32'h0,        32'h0};
        tv[3]  = '{1'b0, 32'hC,  32'h0,        32'h0};
        tv[4]  = '{1'b1, 32'h8,  32'hFFFF_FFFF, 32'h0};
        tv[5]  = '{1'b0, 32'h8,  32'h0,        32'h03FF_03FF};
        tv[6]  = '{1'b0, 32'h18, 32'h0,        32'h03FF_03FF};
        tv[7]  = '{1'b1, 32'h0,  32'hFFFF_FFFF, 32'h0};
        tv[8]  = '{1'b0, 32'h0,  32'h0,        32'h0001_FFFF};
        tv[9]  = '{1'b1, 32'h2,  32'h1234_5678, 32'h0};
        tv[10] = '{1'b0, 32'h2,  32'h0,        32'h0};
        tv[11] = '{1'b0, 32'h0,  32'h0,        32'h0001_FFFF};
        tv[12] = '{1'b1, 32'h8,  32'h0,        32'h0};
        tv[13] = '{1'b1, 32'h0,  32'h0001_0004, 32'h0};
        tv[14] = '{1'b0, 32'h0,  32'h0,        32'h0001_0004};
        model_reset();
        tick();
        tick();
        rd_chk("data_in_rst", 32'h0, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 15; k++)
            if (tv[k].we) wr(tv[k].addr, tv[k].data);
            else rd_chk($sformatf("tbl%0d", k), tv[k].addr, tv[k].exp);

        pins[0] = 1'b1;
        wait_filt("thr4_rise_lat", 0, 1'b1, 6);
        rd_chk("thr4_rise_stat", 32'h4, 32'h0000_0001);
        pins[0] = 1'b0;
        wait_filt("thr4_fall_lat", 0, 1'b0, 6);
        rd_chk("thr4_fall_stat", 32'h4, 32'h0001_0001);
        wr(32'h4, 32'hFFFF_FFFF);
        rd_chk("w1c_all", 32'h4, 32'h0);

        wr(32'h0, 32'h0001_0008);
        pins[3] = 1'b1;
        repeat (5) tick();
        pins[3] = 1'b0;
        repeat (20) tick();
        chk("glitch_filt3", 32'(filt[3]), 32'h0);
        rd_chk("glitch_stat", 32'h4, 32'h0);
        pins[3] = 1'b1;
        repeat (9) tick();
        pins[3] = 1'b0;
        repeat (20) tick();
        rd_chk("pulse9_stat", 32'h4, 32'h0008_0008);
        wr(32'h4, 32'hFFFF_FFFF);

        wr(32'h8, 32'h0000_0004);
        pins[2] = 1'b1;
        wait_filt("p2_rise_lat", 2, 1'b1, 10);
        chk("irq_set", 32'(irq), 32'h1);
        rd_chk("p2_stat", 32'h4, 32'h0000_0004);
        wr(32'h4, 32'h4);
        chk("irq_clr", 32'(irq), 32'h0);
        pins[2] = 1'b0;
        wait_filt("p2_fall_lat", 2, 1'b0, 10);
        pins[2] = 1'b1;
        repeat (9) tick();
        chk("p2_pre_rise", 32'(filt[2]), 32'h0);
        wr(32'h4, 32'h4);
        chk("p2_rise_w1c", 32'(filt[2]), 32'h1);
        rd_chk("set_wins", 32'h4, 32'h0004_0004);
        chk("irq_set_wins", 32'(irq), 32'h1);

        wr(32'h0, 32'h0);
        pins[5] = 1'b1;
        wait_filt("en0_lat", 5, 1'b1, 3);
        wr(32'h0, 32'h0001_0000);
        pins[5] = 1'b0;
        wait_filt("thr0_lat", 5, 1'b0, 3);

        wr(32'h0, 32'h0001_0064);
        pins[7] = 1'b1;
        repeat (50) tick();
        chk("thr100_hold", 32'(filt[7]), 32'h0);
        rst = 1'b1;
        rd_chk("rd_during_rst", 32'h0, 32'h0);
        chk("irq_during_rst", 32'(irq), 32'h0);
        tick();
        rst = 1'b0;
        rd_chk("rst_cfg", 32'h0, 32'h0001_0010);
        rd_chk("rst_stat", 32'h4, 32'h0);
        rd_chk("rst_irqen", 32'h8, 32'h0);
        wait_filt("rst_restart_lat", 7, 1'b1, 18);

        repeat (3) begin
            pins[0] = 1'b1;
            repeat (20) tick();
            pins[0] = 1'b0;
            repeat (20) tick();
        end
        rd_chk("edge_cnt3", 32'hC, EC_ON ? 32'd3 : 32'd0);
        pins[0] = 1'b1;
        repeat (17) tick();
        wr(32'hC, 32'h0);
        chk("ec_edge_rise", 32'(filt[0]), 32'h1);
        rd_chk("edge_cnt_clr", 32'hC, 32'h0);

        for (int r = 0; r < 6; r++) begin
            wr(32'h0, {15'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 6))});
            wr(32'h8, $urandom);
            for (int c = 0; c < 300; c++) begin
                int op;
                if ($urandom_range(0, 7) == 0) pins[$urandom_range(0, NP - 1)] ^= 1'b1;
                op = $urandom_range(0, 63);
                if (op == 0) wr(32'h0, {15'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7))});
                else if (op < 5) wr(32'h4, $urandom);
                else if (op == 5) wr(32'hC, $urandom);
                else begin
                    logic [31:0] a;
                    a = 32'($urandom_range(0, 15));
                    rd_chk("rand_rd", a, m_rd(a));
                    tick();
                end
            end
            rd_chk("rand_stat", 32'h4, m_rd(32'h4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Input conditioning stage directly upstream of the GPIO block.
- Synchronises the raw pad inputs, debounces each pin, and drives the GPIO block's 10-bit pin input with clean levels.
- Captures rising and falling edges in W1C status flags and raises a level interrupt.
- Bus-slave register interface uses the same write-enable, address and data style as the other peripherals.

Parameters:
- NUM_PINS, 10, number of filtered pins (1..16).
- SYNC_STAGES, 2, synchroniser flops per pin (>=2).
- DB_RST, 16'd16, reset value of the debounce threshold field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- we_i  in  1  bus write strobe.
- addr_i  in  32  bus address; only [3:0] decoded.
- data_i  in  32  bus write data.
- data_o  out  32  bus read data, combinational.
- pin_async_i  in  NUM_PINS  raw pad inputs, asynchronous.
- filt_o  out  NUM_PINS  debounced levels; drives the GPIO block's io_pin_i.
- irq_o  out  1  level interrupt, equal to |(status & irq_en).

Behaviour:
- Reset (rst=1 at a clk edge) clears the following: sync chain, counters, filt_o, STATUS and IRQ_EN.
- Reset loads CFG.THR=DB_RST and CFG.EN=1.
- While rst=1: data_o=0 and irq_o=0. Reset mid-debounce discards partial counts.
- After reset, a pin held high produces a rise flag once the latency below has elapsed. This is intended.
- Register map:
  - 0x0 CFG: [15:0] THR, [16] EN. Read/write; other bits read 0.
  - 0x4 STATUS: [15:0] rise flags, [31:16] fall flags, bit i per pin. Write 1 to clear; bits >= NUM_PINS read 0.
  - 0x8 IRQ_EN: same layout as STATUS. Read/write.
  - Other offsets: read 0, writes ignored.
- Synchroniser: each pin passes through SYNC_STAGES flops; s[i] is the last stage.
- Debounce, EN=1, per pin, 16-bit counter cnt:
  - If s==filt: cnt<=0.
  - Else, if cnt+1 >= max(THR,1): filt<=s and cnt<=0.
  - Else: cnt<=cnt+1.
  - cnt saturates and never exceeds THR.
  - Any return of s to filt before the threshold is reached restarts the count.
  - Latency from a pin change to filt_o: SYNC_STAGES + max(THR,1) cycles.
- EN=0: filt<=s every cycle; counters held at 0. Latency is SYNC_STAGES+1.
- THR written mid-count: the compare uses the new THR from the next cycle. If cnt >= new THR, filt updates on that cycle.
- Edge capture:
  - filt 0->1 sets rise[i]; 1->0 sets fall[i], on the same edge that filt updates.
  - A set event and a W1C of the same bit in the same cycle: set wins.
  - Flags are sticky until cleared.
- irq_o is combinational from the registered STATUS and IRQ_EN. It asserts the cycle after the flag-setting edge.

Optional Feature:
- Macro GPIO_IN_FILTER_EDGE_CNT_EN.
- Defined:
  - Adds register 0xC EDGE_CNT: [15:0] counts pin-0 filtered rising edges, wrapping 0xFFFF->0.
  - Any write to 0xC clears the count.
  - An increment coinciding with a clearing write yields 0.
  - Reset value is 0.
- Undefined: 0xC reads 0 and the counter logic is absent.

Decomposition:
- Shared package holds:
  - the register offsets GPIO_IN_CFG=4'h0, GPIO_IN_STATUS=4'h4, GPIO_IN_IRQEN=4'h8, GPIO_IN_EDGECNT=4'hC;
  - CFG field positions: THR [15:0], EN bit 16;
  - the 16-bit counter width constant.
- One natural sub-module: gpio_in_debounce_cell, covering one pin's sync chain, counter and filt flop. It is instantiated NUM_PINS times.
- The top holds the registers, edge capture, read mux and irq.

Test Plan:
- Reset then read 0x0 -> 0x0001_0010. Read 0x4 and 0x8 -> 0. filt_o=0, irq_o=0.
- THR=4, EN=1:
  - pin0 rises and holds -> filt_o[0] rises exactly 6 cycles later (2+4), STATUS=0x0000_0001.
  - Then pin0 falls -> STATUS=0x0001_0001.
- THR=8: pin3 toggles high for 5 cycles and then low -> filt_o[3] never changes, STATUS unchanged. A 9-cycle high pulse -> rise[3] and later fall[3] both set.
- IRQ_EN=0x0000_0004, pin2 rise -> irq_o=1 one cycle after the flag sets.
  - Write 0x4 with 0x4 -> irq_o=0 next cycle.
  - A W1C in the same cycle as a new rise keeps the flag set.
- Write CFG=0 (EN=0): pin5 change -> filt_o[5] follows after 3 cycles.
- Assert rst for 1 cycle mid-count (THR=100, 50 cycles in) -> all registers reset and the count restarts. Pin held high -> rise after 2+16 cycles.
- With GPIO_IN_FILTER_EDGE_CNT_EN defined: 3 pin-0 pulses -> 0xC reads 3. A clearing write to 0xC concurrent with a 4th edge -> reads 0.
